keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end that produces the debounced one-hot digit vector consumed by the countdown timer's setting mode. Drives the column lines of a 4x3 keypad (1-9, *, 0, #), samples the rows, debounces one key at a time and presents it as a level-held one-hot `keypad[9:0]` plus a one-cycle `key_valid` strobe. Runs on the same 1 kHz system clock as the timer; one clock = 1 ms.

## Interface
- `DEBOUNCE_MS`, 20, consecutive matching samples required to accept a press or a release (2..255)
- `REPEAT_DELAY_MS`, 500, hold time before the first auto-repeat (used only with `KEYPAD_REPEAT_EN`)
- `REPEAT_PERIOD_MS`, 100, interval between auto-repeats (used only with `KEYPAD_REPEAT_EN`)
- `clk`  in  1  system clock, 1 kHz
- `rst`  in  1  reset, asynchronous, active-high
- `row_n`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`
- `col_n`  out  3  column strobes, active-low, exactly one low at a time
- `keypad`  out  10  one-hot digit, bit n = digit n; all zero for none, `*` or `#`
- `key_code`  out  4  0-9 digit, 10 = `*`, 11 = `#`; 0 when idle
- `key_star`  out  1  level, `*` held
- `key_hash`  out  1  level, `#` held
- `key_valid`  out  1  one-cycle strobe per accepted press (and per repeat)

## Operation
- Key map (row, col): r0 = 1 2 3; r1 = 4 5 6; r2 = 7 8 9; r3 = * 0 #; col0 = leftmost.
- `row_n` passes through a 2-flop synchronizer; all decisions use the synchronized value.
- States: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN: each column is held low for a 4-clock slot (2-bit slot counter); rows sampled on the last clock of the slot; then advance col0→col1→col2→col0. Full scan = 12 clocks.
- Sample with exactly one row low → latch (row, col), freeze the column, go DEBOUNCE with match count = 1. Zero rows or two-or-more rows low → no candidate, keep scanning (ghosting/multi-press rejected).
- DEBOUNCE: column frozen; each clock, same row pattern → count+1, otherwise → SCAN (resume at next column). Count reaching `DEBOUNCE_MS` → PRESSED; drive outputs and pulse `key_valid` on that edge.
- PRESSED: outputs held. Any deviation from the latched pattern → RELEASE, release count = 1.
- RELEASE: outputs still held. Rows all high → count+1; latched pattern returns → PRESSED (no new `key_valid`); other pattern → count reset to 0. Count reaching `DEBOUNCE_MS` → SCAN, clear `keypad`, `key_code`, `key_star`, `key_hash` on that edge, resume scan at col0.
- A second key pressed while one is held is ignored until the first is released and the scan resumes.

## Timing
- Reset values: `col_n` = 3'b110, `keypad` = 0, `key_code` = 0, `key_star` = 0, `key_hash` = 0, `key_valid` = 0, state SCAN, all counters 0.
- Press latency (row edge to `key_valid`): 2 sync + 0..11 scan wait + (`DEBOUNCE_MS` − 1) clocks.
- Release latency (row high to outputs cleared): 2 + `DEBOUNCE_MS` − 1 clocks.
- `key_valid` is coincident with the first cycle `keypad` becomes non-zero; never asserted while outputs are zero.
- Counters saturate at their target; no wrap.
- `rst` mid-press: immediate return to reset values; a still-held key is re-detected and re-debounced after release of `rst` (one new `key_valid`).

## Configuration
- `KEYPAD_REPEAT_EN` defined: in PRESSED a hold counter runs; `key_valid` re-pulses `REPEAT_DELAY_MS` clocks after the initial strobe, then every `REPEAT_PERIOD_MS` clocks while the key stays in PRESSED. RELEASE freezes the hold counter; return to PRESSED resumes it; SCAN clears it.
- Undefined: exactly one `key_valid` per press; repeat parameters ignored; hold counter not built.

## Test plan
- Reset: assert `rst` mid-scan → all outputs 0, `col_n` = 3'b110 on the same cycle; release → columns cycle 110→101→011 every 4 clocks.
- Clean press of `5` (r1 low when col1 low) held 100 ms, DEBOUNCE_MS = 20 → single `key_valid`, `keypad` = 10'b0000100000, `key_code` = 5; cleared 21 clocks after rows go high.
- Bounce: `7` toggling every 3 ms for 15 ms, then stable → no `key_valid` during bounce, exactly one after 20 stable samples, `keypad` = 10'b0010000000.
- `#` press → `key_hash` = 1, `key_code` = 11, `keypad` = 0, one `key_valid`; concurrent `1` and `4` (two rows on col0) → no key accepted.
- Release glitch: hold `0`, rows high for 5 ms then low again → outputs stay `key_code` = 0, `keypad` = 10'b0000000001, no second `key_valid`.
- With `KEYPAD_REPEAT_EN`, hold `9` for 800 ms → `key_valid` at press, +500, +600, +700 ms (4 strobes); without macro → 1 strobe.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scan, debounce and one-hot digit output.
// Define KEYPAD_REPEAT_EN to re-strobe key_valid while a key stays held.
module keypad_scanner #(
  parameter int DEBOUNCE_MS      = 20,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [9:0] keypad,
  output logic [3:0] key_code,
  output logic       key_star,
  output logic       key_hash,
  output logic       key_valid
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [7:0] DB = 8'(DEBOUNCE_MS);
  if (DEBOUNCE_MS < 2 || DEBOUNCE_MS > 255 || REPEAT_DELAY_MS < 1 || REPEAT_PERIOD_MS < 1) begin : g_bad_cfg
    $error("keypad_scanner: parameter out of range");
  end
  state_t     r_state, w_state;
  logic [3:0] r_sync1, r_sync2, r_pat, w_pat, r_code, w_code, w_cand, w_low;
  logic [1:0] r_col, w_col, r_slot, w_slot, w_next_col, w_ridx;
  logic [7:0] r_cnt, w_cnt;
  logic       w_one, w_valid, w_load, w_clear, w_strobe;
  assign col_n      = ~(3'b001 << r_col);
  assign w_low      = ~r_sync2;
  assign w_one      = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_ridx     = w_low[0] ? 2'd0 : w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : 2'd3;
  assign w_next_col = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
  // bottom row is * 0 #, the other rows count 1..9 left to right
  assign w_cand = (w_ridx == 2'd3) ? (r_col == 2'd0 ? 4'd10 : r_col == 2'd1 ? 4'd0 : 4'd11)
                                   : {2'b0, w_ridx} * 4'd3 + {2'b0, r_col} + 4'd1;
  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_slot  = r_slot;
    w_cnt   = r_cnt;
    w_pat   = r_pat;
    w_code  = r_code;
    w_valid = 1'b0;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      SCAN: begin
        w_slot = r_slot + 2'd1;
        if (r_slot == 2'd3 && w_one) begin
          w_state = DEBOUNCE;
          w_cnt   = 8'd1;
          w_pat   = r_sync2;
          w_code  = w_cand;
        end else if (r_slot == 2'd3) w_col = w_next_col;
      end
      DEBOUNCE:
        if (r_sync2 != r_pat) begin
          w_state = SCAN;
          w_col   = w_next_col;
          w_slot  = 2'd0;
          w_cnt   = 8'd0;
        end else if (r_cnt + 8'd1 >= DB) begin
          w_state = PRESSED;
          w_cnt   = DB;
          w_valid = 1'b1;
          w_load  = 1'b1;
        end else w_cnt = r_cnt + 8'd1;
      PRESSED:
        if (r_sync2 != r_pat) begin
          w_state = RELEASE;
          w_cnt   = 8'd1;
        end
      RELEASE:
        if (r_sync2 == r_pat) w_state = PRESSED;
        else if (&r_sync2 && r_cnt + 8'd1 >= DB) begin
          w_state = SCAN;
          w_col   = 2'd0;
          w_slot  = 2'd0;
          w_cnt   = 8'd0;
          w_clear = 1'b1;
        end else w_cnt = &r_sync2 ? r_cnt + 8'd1 : 8'd0;
    endcase
  end
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RD = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] RP = 16'(REPEAT_PERIOD_MS);
  logic [15:0] r_hold, w_hold;
  logic        r_rep, w_rep, w_repeat;
  always_comb begin
    w_hold   = r_hold;
    w_rep    = r_rep;
    w_repeat = 1'b0;
    if (r_state == SCAN || r_state == DEBOUNCE) begin
      w_hold = 16'd0;
      w_rep  = 1'b0;
    end else if (r_state == PRESSED && r_sync2 == r_pat) begin
      w_repeat = (r_hold + 16'd1 >= (r_rep ? RP : RD));
      w_hold   = w_repeat ? 16'd0 : r_hold + 16'd1;
      w_rep    = r_rep | w_repeat;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hold <= 16'd0;
      r_rep  <= 1'b0;
    end else begin
      r_hold <= w_hold;
      r_rep  <= w_rep;
    end
  assign w_strobe = w_valid | w_repeat;
`else
  assign w_strobe = w_valid;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= SCAN;
      r_sync1   <= 4'hF;
      r_sync2   <= 4'hF;
      r_col     <= 2'd0;
      r_slot    <= 2'd0;
      r_cnt     <= 8'd0;
      r_pat     <= 4'hF;
      r_code    <= 4'd0;
      keypad    <= 10'd0;
      key_code  <= 4'd0;
      key_star  <= 1'b0;
      key_hash  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      r_sync1   <= row_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state;
      r_col     <= w_col;
      r_slot    <= w_slot;
      r_cnt     <= w_cnt;
      r_pat     <= w_pat;
      r_code    <= w_code;
      key_valid <= w_strobe;
      if (w_load) begin
        keypad   <= (r_code < 4'd10) ? 10'd1 << r_code : 10'd0;
        key_code <= r_code;
        key_star <= (r_code == 4'd10);
        key_hash <= (r_code == 4'd11);
      end else if (w_clear) begin
        keypad   <= 10'd0;
        key_code <= 4'd0;
        key_star <= 1'b0;
        key_hash <= 1'b0;
      end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad presses against a scoreboard of expected strobes.
module tb_keypad_scanner;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] keypad;
  logic [3:0] key_code;
  logic key_star, key_hash, key_valid;
  logic [11:0] held = 12'd0;
  int n_assert = 0, n_fail = 0, n_valid = 0;
  typedef struct {logic [9:0] kp; logic [3:0] code; logic star; logic hash;} exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  keypad_scanner dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .keypad(keypad),
    .key_code(key_code), .key_star(key_star), .key_hash(key_hash), .key_valid(key_valid)
  );
  // held[r*3+c] closes the switch between row r and column c
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (held[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [9:0] kp, input logic [3:0] code, input logic s, input logic h);
    sb.push_back('{kp, code, s, h});
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_valid(input string tag, input int target, input int budget);
    int i = 0;
    while (n_valid < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(n_valid >= target), 1);
  endtask
  task automatic wait_clear(input string tag, input int budget);
    int i = 0;
    while ((keypad != 10'd0 || key_code != 4'd0 || key_star || key_hash) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(i < budget), 1);
  endtask
  always @(negedge clk)
    if (!rst && key_valid) begin
      n_valid++;
      check("strobe_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_keypad", 32'(keypad), 32'(e.kp));
        check("strobe_code", 32'(key_code), 32'(e.code));
        check("strobe_star", 32'(key_star), 32'(e.star));
        check("strobe_hash", 32'(key_hash), 32'(e.hash));
      end
    end
  initial begin
    int v, n, reps;
    cycles(3);
    check("rst_col", 32'(col_n), 6);
    check("rst_keypad", 32'(keypad), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_flags", 32'({key_star, key_hash, key_valid}), 0);
    rst = 1'b0;
    cycles(6);
    check("scan_mid_col", 32'(col_n), 5);
    rst = 1'b1;
    #1;
    check("async_rst_col", 32'(col_n), 6);
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    check("scan_col0", 32'(col_n), 6);
    cycles(3);
    check("scan_col1", 32'(col_n), 5);
    cycles(4);
    check("scan_col2", 32'(col_n), 3);
    cycles(4);
    check("scan_wrap", 32'(col_n), 6);
    v = n_valid;
    push(10'b0000100000, 4'd5, 1'b0, 1'b0);
    held[4] = 1'b1;
    wait_valid("press5", v + 1, 60);
    cycles(80);
    check("press5_once", 32'(n_valid), 32'(v + 1));
    check("press5_keypad", 32'(keypad), 32'h20);
    check("press5_code", 32'(key_code), 5);
    held = 12'd0;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (keypad == 10'd0) break;
    end
    check("rel5_latency", 32'(n), 21);
    check("rel5_code", 32'(key_code), 0);
    cycles(5);
    v = n_valid;
    push(10'b0010000000, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      held[6] = ~held[6];
      cycles(3);
    end
    held[6] = 1'b1;
    check("bounce_quiet", 32'(n_valid), 32'(v));
    wait_valid("bounce7", v + 1, 60);
    cycles(30);
    check("bounce7_once", 32'(n_valid), 32'(v + 1));
    check("bounce7_keypad", 32'(keypad), 32'h80);
    held = 12'd0;
    wait_clear("clr7", 40);
    v = n_valid;
    push(10'd0, 4'd11, 1'b0, 1'b1);
    held[11] = 1'b1;
    wait_valid("hash", v + 1, 60);
    cycles(10);
    check("hash_level", 32'(key_hash), 1);
    check("hash_code", 32'(key_code), 11);
    check("hash_keypad", 32'(keypad), 0);
    check("hash_once", 32'(n_valid), 32'(v + 1));
    held = 12'd0;
    wait_clear("clr_hash", 40);
    v = n_valid;
    held[0] = 1'b1;
    held[3] = 1'b1;
    cycles(100);
    check("ghost_none", 32'(n_valid), 32'(v));
    check("ghost_keypad", 32'(keypad), 0);
    held = 12'd0;
    cycles(5);
    v = n_valid;
    push(10'b0000000001, 4'd0, 1'b0, 1'b0);
    held[10] = 1'b1;
    wait_valid("press0", v + 1, 60);
    cycles(10);
    held[10] = 1'b0;
    cycles(5);
    held[10] = 1'b1;
    cycles(40);
    check("glitch_once", 32'(n_valid), 32'(v + 1));
    check("glitch_keypad", 32'(keypad), 1);
    check("glitch_code", 32'(key_code), 0);
    held = 12'd0;
    wait_clear("clr0", 40);
    v = n_valid;
    push(10'b0000000100, 4'd2, 1'b0, 1'b0);
    held[1] = 1'b1;
    wait_valid("press2", v + 1, 60);
    cycles(5);
    rst = 1'b1;
    #1;
    check("midrst_keypad", 32'(keypad), 0);
    check("midrst_code", 32'(key_code), 0);
    check("midrst_col", 32'(col_n), 6);
    cycles(3);
    push(10'b0000000100, 4'd2, 1'b0, 1'b0);
    rst = 1'b0;
    wait_valid("redetect2", v + 2, 60);
    cycles(30);
    check("redetect2_once", 32'(n_valid), 32'(v + 2));
    check("redetect2_keypad", 32'(keypad), 4);
    held = 12'd0;
    wait_clear("clr2", 40);
    v = n_valid;
`ifdef KEYPAD_REPEAT_EN
    reps = 4;
`else
    reps = 1;
`endif
    for (int i = 0; i < reps; i++) push(10'b1000000000, 4'd9, 1'b0, 1'b0);
    held[8] = 1'b1;
    wait_valid("press9", v + 1, 60);
    cycles(780);
    held = 12'd0;
    wait_clear("clr9", 40);
    check("hold9_strobes", 32'(n_valid), 32'(v + reps));
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
